mem_arbiter: RTL and testbench

Shares the single 64-bit physical-memory port between the instruction-fetch (IF) requester and the load/store (LSU) requester, so that the core can move from a one-cycle combinational memory model to a multi-cycle, handshaked memory. It sits between the PC/fetch logic, the data-memory access path and the pmem bridge. It accepts at most one outstanding transaction at a time. It latches the winning request, drives it downstream with valid/ready, waits for the response (with a timeout), and returns the data to the owner.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_grant.sv | 36 +++
 rtl/mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LSU memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam int MAX_WAIT_DEFAULT = 255;

endpackage

// File: rtl/mem_arb_grant.sv
// One-hot grant between the IF and LSU requesters, indexed by OWN_IF/OWN_LS.
// MEM_ARB_RR_EN selects round-robin; otherwise LSU has fixed priority over IF.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic       if_valid,
  input  logic       ls_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant = '0;
    if (if_valid && ls_valid) begin
      // Contended: the requester that did not win last time goes now.
      if (last_grant == OWN_IF) grant[OWN_LS] = 1'b1;
      else                      grant[OWN_IF] = 1'b1;
    end else if (ls_valid) begin
      grant[OWN_LS] = 1'b1;
    end else if (if_valid) begin
      grant[OWN_IF] = 1'b1;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = '0;
    if (ls_valid)      grant[OWN_LS] = 1'b1;
    else if (if_valid) grant[OWN_IF] = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one handshaked memory port between IF and LSU, one transaction in flight,
// with a WAIT timeout. Define MEM_ARB_RR_EN for round-robin instead of LSU priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_resp_err,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_WAIT + 1);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                if_resp_valid_q, if_resp_valid_d;
  logic                ls_resp_valid_q, ls_resp_valid_d;
  logic                if_resp_err_q, if_resp_err_d;
  logic                ls_resp_err_q, ls_resp_err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;

  logic [1:0]          grant;
  logic                last_grant;
  logic                timeout;
  logic [DATA_W-1:0]   resp_data;

  mem_arb_grant u_grant (
    .if_valid   (if_req_valid),
    .ls_valid   (ls_req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready is gated by rst so nothing can be accepted while reset is held.
  assign if_req_ready = rst && (state_q == IDLE) && grant[OWN_IF];
  assign ls_req_ready = rst && (state_q == IDLE) && grant[OWN_LS];

  // A response in the final WAIT cycle beats the timeout.
  assign timeout   = !mem_resp_valid && (cnt_q == CNT_W'(MAX_WAIT - 1));
  assign resp_data = (mem_resp_valid && !wen_q) ? mem_rdata : '0;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (ls_req_ready)      last_grant_d = OWN_LS;
    else if (if_req_ready) last_grant_d = OWN_IF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= OWN_IF;
    else      last_grant_q <= last_grant_d;
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = OWN_IF;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d         = state_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    mem_req_valid_d = mem_req_valid_q;
    cnt_d           = '0;
    if_resp_valid_d = 1'b0;
    ls_resp_valid_d = 1'b0;
    if_resp_err_d   = 1'b0;
    ls_resp_err_d   = 1'b0;
    if_rdata_d      = if_rdata_q;
    ls_rdata_d      = ls_rdata_q;

    case (state_q)
      IDLE: begin
        if (ls_req_ready) begin
          owner_d         = OWN_LS;
          addr_d          = ls_addr;
          wen_d           = ls_wen;
          wdata_d         = ls_wdata;
          wmask_d         = ls_wen ? ls_wmask : '0;
          mem_req_valid_d = 1'b1;
          state_d         = REQ;
        end else if (if_req_ready) begin
          owner_d         = OWN_IF;
          addr_d          = if_addr;
          wen_d           = 1'b0;
          wdata_d         = '0;
          wmask_d         = '0;
          mem_req_valid_d = 1'b1;
          state_d         = REQ;
        end
      end

      REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = WAIT;
        end
      end

      WAIT: begin
        if (mem_resp_valid || timeout) begin
          state_d = IDLE;
          if (owner_q == OWN_LS) begin
            ls_resp_valid_d = 1'b1;
            ls_resp_err_d   = timeout;
            ls_rdata_d      = resp_data;
          end else begin
            if_resp_valid_d = 1'b1;
            if_resp_err_d   = timeout;
            if_rdata_d      = resp_data;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: data/address registers are reset too, because they drive module outputs that must read 0 in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      owner_q         <= OWN_IF;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      mem_req_valid_q <= 1'b0;
      cnt_q           <= '0;
      if_resp_valid_q <= 1'b0;
      ls_resp_valid_q <= 1'b0;
      if_resp_err_q   <= 1'b0;
      ls_resp_err_q   <= 1'b0;
      if_rdata_q      <= '0;
      ls_rdata_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q         <= state_d;
      owner_q         <= owner_d;
      addr_q          <= addr_d;
      wen_q           <= wen_d;
      wdata_q         <= wdata_d;
      wmask_q         <= wmask_d;
      mem_req_valid_q <= mem_req_valid_d;
      cnt_q           <= cnt_d;
      if_resp_valid_q <= if_resp_valid_d;
      ls_resp_valid_q <= ls_resp_valid_d;
      if_resp_err_q   <= if_resp_err_d;
      ls_resp_err_q   <= ls_resp_err_d;
      if_rdata_q      <= if_rdata_d;
      ls_rdata_q      <= ls_rdata_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign if_resp_valid = if_resp_valid_q;
  assign if_resp_err   = if_resp_err_q;
  assign if_rdata      = if_rdata_q;
  assign ls_resp_valid = ls_resp_valid_q;
  assign ls_resp_err   = ls_resp_err_q;
  assign ls_rdata      = ls_rdata_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MAX_WAIT = 4) with a response scoreboard queue.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int MW   = DW / 8;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid, ls_resp_err;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic [MW-1:0] ls_wmask;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_resp_err(ls_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    logic          owner;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic owner, input logic [DW-1:0] rdata, input logic err);
    exp_t e;
    e.owner = owner;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Pops the oldest expected response and compares it with what the DUT shows now.
  task automatic expect_resp(input string tag);
    exp_t e;
    check({tag, ":pending"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ":if_valid"}, 64'(if_resp_valid), 64'(e.owner == OWN_IF));
      check({tag, ":ls_valid"}, 64'(ls_resp_valid), 64'(e.owner == OWN_LS));
      if (e.owner == OWN_IF) begin
        check({tag, ":if_rdata"}, if_rdata, e.rdata);
        check({tag, ":if_err"}, 64'(if_resp_err), 64'(e.err));
      end else begin
        check({tag, ":ls_rdata"}, ls_rdata, e.rdata);
        check({tag, ":ls_err"}, 64'(ls_resp_err), 64'(e.err));
      end
    end
  endtask

  task automatic no_resp(input string tag);
    check({tag, ":if_valid0"}, 64'(if_resp_valid), 64'd0);
    check({tag, ":ls_valid0"}, 64'(ls_resp_valid), 64'd0);
  endtask

  // Called in the REQ cycle: accept at once, respond in the first WAIT cycle.
  task automatic serve(input string tag, input logic [DW-1:0] rdata);
    check({tag, ":req_valid"}, 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check({tag, ":req_drop"}, 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    step();
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  initial begin
    logic          exp_own;
    logic [DW-1:0] d;

    rst = 1'b0;
    if_req_valid = 1'b1; if_addr = '0;
    ls_req_valid = 1'b1; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;

    // Reset state, with both requesters asking.
    #3;
    check("rst:if_ready", 64'(if_req_ready), 64'd0);
    check("rst:ls_ready", 64'(ls_req_ready), 64'd0);
    check("rst:mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:mem_addr", mem_addr, 64'd0);
    no_resp("rst");
    step();
    step();
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    rst = 1'b1;
    step();

    // LSU write: fields latched, held while mem_req_ready is low, rdata forced to 0.
    ls_req_valid = 1'b1; ls_addr = 64'h8000_1000; ls_wen = 1'b1;
    ls_wdata = 64'h1122_3344_5566_7788; ls_wmask = 8'h0F;
    #1;
    check("wr:ls_ready", 64'(ls_req_ready), 64'd1);
    check("wr:if_ready", 64'(if_req_ready), 64'd0);
    push(OWN_LS, '0, 1'b0);
    step();
    ls_req_valid = 1'b0; ls_addr = '1; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      check("wr:mem_req_valid", 64'(mem_req_valid), 64'd1);
      check("wr:mem_addr", mem_addr, 64'h8000_1000);
      check("wr:mem_wen", 64'(mem_wen), 64'd1);
      check("wr:mem_wdata", mem_wdata, 64'h1122_3344_5566_7788);
      check("wr:mem_wmask", 64'(mem_wmask), 64'h0F);
      step();
    end
    serve("wr", 64'hDEAD_BEEF);
    expect_resp("wr");
    step();
    no_resp("wr_pulse");

    // Lone IF read: accept in cycle 0, response pulse in cycle 3.
    if_req_valid = 1'b1; if_addr = 64'h8000_0000;
    #1;
    check("if:if_ready", 64'(if_req_ready), 64'd1);
    push(OWN_IF, 64'h0000_0013_0010_0073, 1'b0);
    step();
    if_req_valid = 1'b0;
    check("if:mem_addr", mem_addr, 64'h8000_0000);
    check("if:mem_wen", 64'(mem_wen), 64'd0);
    check("if:mem_wmask", 64'(mem_wmask), 64'd0);
    check("if:busy", 64'(busy), 64'd1);
    serve("if", 64'h0000_0013_0010_0073);
    expect_resp("if");
    step();
    no_resp("if_pulse");

    // Contention, back-to-back; LSU is a read with a non-zero mask that must be dropped.
    ls_req_valid = 1'b1; ls_addr = 64'h8000_2000; ls_wen = 1'b0; ls_wmask = 8'hFF;
    ls_wdata = 64'h55;
    if_req_valid = 1'b1; if_addr = 64'h8000_0100;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_own = (i % 2 == 0) ? OWN_LS : OWN_IF;
`else
      exp_own = OWN_LS;
`endif
      #1;
      check("arb:if_ready", 64'(if_req_ready), 64'(exp_own == OWN_IF));
      check("arb:ls_ready", 64'(ls_req_ready), 64'(exp_own == OWN_LS));
      d = 64'hA0 + 64'(i);
      push(exp_own, d, 1'b0);
      step();
      check("arb:mem_addr", mem_addr, (exp_own == OWN_LS) ? 64'h8000_2000 : 64'h8000_0100);
      check("arb:mem_wmask", 64'(mem_wmask), 64'd0);
      serve("arb", d);
      expect_resp("arb");
      if (i == 3) begin
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
      end
    end
    step();
    no_resp("arb_pulse");
    check("arb:busy", 64'(busy), 64'd0);

    // mem_req_ready low for 10 cycles, with both requesters and a stray response pending.
    if_req_valid = 1'b1; if_addr = 64'h8000_0200;
    #1;
    push(OWN_IF, 64'h77, 1'b0);
    step();
    if_addr = 64'h1234; ls_req_valid = 1'b1; ls_addr = 64'h5678; mem_resp_valid = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      check("stall:mem_req_valid", 64'(mem_req_valid), 64'd1);
      check("stall:mem_addr", mem_addr, 64'h8000_0200);
      check("stall:busy", 64'(busy), 64'd1);
      check("stall:if_ready", 64'(if_req_ready), 64'd0);
      check("stall:ls_ready", 64'(ls_req_ready), 64'd0);
      no_resp("stall");
      step();
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0; mem_resp_valid = 1'b0;
    serve("stall", 64'h77);
    expect_resp("stall");
    step();

    // Timeout: no response for MAX_WAIT WAIT cycles, then a late response in IDLE.
    ls_req_valid = 1'b1; ls_addr = 64'h8000_3000; ls_wen = 1'b0;
    #1;
    check("tmo:ls_ready", 64'(ls_req_ready), 64'd1);
    push(OWN_LS, '0, 1'b1);
    step();
    ls_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int k = 0; k < MAXW; k++) begin
      no_resp("tmo_wait");
      check("tmo:busy", 64'(busy), 64'd1);
      step();
    end
    expect_resp("tmo");
    check("tmo:busy_idle", 64'(busy), 64'd0);
    mem_resp_valid = 1'b1; mem_rdata = 64'hBAD;
    step();
    mem_resp_valid = 1'b0;
    no_resp("late");
    check("late:busy", 64'(busy), 64'd0);
    step();
    no_resp("late2");

    // Response in the last WAIT cycle wins over the timeout.
    ls_req_valid = 1'b1; ls_addr = 64'h8000_3008;
    #1;
    push(OWN_LS, 64'hCAFE_F00D, 1'b0);
    step();
    ls_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int k = 0; k < MAXW - 1; k++) step();
    mem_resp_valid = 1'b1; mem_rdata = 64'hCAFE_F00D;
    step();
    mem_resp_valid = 1'b0;
    expect_resp("edge");
    step();

    // Asynchronous reset during WAIT aborts the transaction silently.
    if_req_valid = 1'b1; if_addr = 64'h8000_4000;
    #1;
    step();
    if_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("arst:busy_before", 64'(busy), 64'd1);
    rst = 1'b0; if_req_valid = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 64'h99;
    #1;
    check("arst:busy", 64'(busy), 64'd0);
    check("arst:mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("arst:mem_addr", mem_addr, 64'd0);
    check("arst:mem_wen", 64'(mem_wen), 64'd0);
    check("arst:mem_wdata", mem_wdata, 64'd0);
    check("arst:mem_wmask", 64'(mem_wmask), 64'd0);
    check("arst:if_rdata", if_rdata, 64'd0);
    check("arst:ls_rdata", ls_rdata, 64'd0);
    check("arst:if_err", 64'(if_resp_err), 64'd0);
    check("arst:ls_err", 64'(ls_resp_err), 64'd0);
    check("arst:if_ready", 64'(if_req_ready), 64'd0);
    no_resp("arst");
    step();
    step();
    if_req_valid = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      no_resp("arst_after");
      step();
    end

    // A fresh IF read after reset completes normally.
    if_req_valid = 1'b1; if_addr = 64'h8000_0040;
    #1;
    check("post:if_ready", 64'(if_req_ready), 64'd1);
    push(OWN_IF, 64'h0123_4567_89AB_CDEF, 1'b0);
    step();
    if_req_valid = 1'b0;
    check("post:mem_addr", mem_addr, 64'h8000_0040);
    serve("post", 64'h0123_4567_89AB_CDEF);
    expect_resp("post");
    step();
    no_resp("post_pulse");

    check("sb:empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
